// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: datapath width, instruction field
// positions, opcode encodings, FSM state encoding and decode helpers.
package alu_sequencer_pkg;

    localparam int WORD_SIZE = 16;
    localparam int NUM_REGS  = 8;
    localparam int REG_AW    = 3;
    localparam int OPC_W     = 5;

    // Instruction field positions
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 11;
    localparam int RD_MSB  = 10;
    localparam int RD_LSB  = 8;
    localparam int RS1_MSB = 7;
    localparam int RS1_LSB = 5;
    localparam int RS2_MSB = 4;
    localparam int RS2_LSB = 2;
    localparam int IMM_MSB = 4;
    localparam int IMM_LSB = 0;

    // Opcodes understood by the downstream ALU
    localparam logic [OPC_W-1:0] OPC_NOT  = 5'd0;
    localparam logic [OPC_W-1:0] OPC_AND  = 5'd1;
    localparam logic [OPC_W-1:0] OPC_OR   = 5'd2;
    localparam logic [OPC_W-1:0] OPC_XOR  = 5'd3;
    localparam logic [OPC_W-1:0] OPC_ADD  = 5'd4;
    localparam logic [OPC_W-1:0] OPC_ADDI = 5'd5;
    localparam logic [OPC_W-1:0] OPC_SUB  = 5'd6;
    localparam logic [OPC_W-1:0] OPC_ANDI = 5'd7;
    localparam logic [OPC_W-1:0] OPC_EQ   = 5'd8;
    localparam logic [OPC_W-1:0] OPC_LT   = 5'd9;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } seq_state_e;

    // Immediate-format instructions take input2 from imm5 instead of rs2
    function automatic logic is_itype(input logic [OPC_W-1:0] opc);
        return (opc == OPC_ADDI) || (opc == OPC_ANDI);
    endfunction

    // Opcodes the sequencer will issue; everything else is flagged illegal
    function automatic logic is_supported(input logic [OPC_W-1:0] opc);
        return opc inside {OPC_NOT, OPC_AND, OPC_OR, OPC_XOR, OPC_ADD,
                           OPC_ADDI, OPC_SUB, OPC_ANDI, OPC_EQ, OPC_LT};
    endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// 8 x WORD_SIZE register file for the ALU sequencer: two combinational
// operand read ports, one combinational debug read port and one write port.
// r0 is hard-wired to zero; writes addressed to it are dropped.
module alu_seq_regfile
    import alu_sequencer_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 we_i,
    input  logic [REG_AW-1:0]    waddr_i,
    input  logic [WORD_SIZE-1:0] wdata_i,
    input  logic [REG_AW-1:0]    raddr1_i,
    input  logic [REG_AW-1:0]    raddr2_i,
    input  logic [REG_AW-1:0]    dbg_addr_i,
    output logic [WORD_SIZE-1:0] rdata1_o,
    output logic [WORD_SIZE-1:0] rdata2_o,
    output logic [WORD_SIZE-1:0] dbg_data_o
);

    logic [WORD_SIZE-1:0] regs_q [NUM_REGS];

    // Register storage: cleared on reset, r0 never written
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o   = (raddr1_i   == '0) ? '0 : regs_q[raddr1_i];
    assign rdata2_o   = (raddr2_i   == '0) ? '0 : regs_q[raddr2_i];
    assign dbg_data_o = (dbg_addr_i == '0) ? '0 : regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_sequencer.sv
// ALU sequencer: accepts register-format instructions, reads operands from
// the local register file, drives the external ALU for ALU_LATENCY edges and
// writes the ALU result back to rd.
// Optional build macro ALU_SEQ_FLAGS_EN adds flag_zero / flag_lt outputs.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int ALU_LATENCY = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [15:0]          instr,
    input  logic                 init_we,
    input  logic [REG_AW-1:0]    init_addr,
    input  logic [WORD_SIZE-1:0] init_data,
    output logic [OPC_W-1:0]     alu_opcode,
    output logic [WORD_SIZE-1:0] alu_input1,
    output logic [WORD_SIZE-1:0] alu_input2,
    output logic                 alu_enable,
    input  logic [WORD_SIZE-1:0] alu_out,
    output logic                 result_valid,
    output logic [WORD_SIZE-1:0] result_data,
    output logic                 illegal_op,
    input  logic [REG_AW-1:0]    dbg_addr,
    output logic [WORD_SIZE-1:0] dbg_data,
    output logic [1:0]           dbg_state
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic                 flag_zero,
    output logic                 flag_lt
`endif
);

    localparam logic [2:0] LAT = 3'(ALU_LATENCY);

    // Handshake: an instruction transfers on a rising edge where
    // instr_valid && instr_ready; instr_ready is high only in IDLE (and never
    // during reset), so instr is ignored while an instruction is in flight.

    seq_state_e           state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [OPC_W-1:0]     opc_q, opc_d;
    logic [REG_AW-1:0]    rd_q, rd_d;
    logic [WORD_SIZE-1:0] in1_q, in1_d;
    logic [WORD_SIZE-1:0] in2_q, in2_d;
    logic [WORD_SIZE-1:0] result_q, result_d;
    logic                 result_valid_q, result_valid_d;
    logic                 illegal_q, illegal_d;

    logic                 rf_we;
    logic [REG_AW-1:0]    rf_waddr;
    logic [WORD_SIZE-1:0] rf_wdata;
    logic [WORD_SIZE-1:0] rs1_data, rs2_data;

    logic [OPC_W-1:0]     instr_opc;
    logic [REG_AW-1:0]    instr_rd, instr_rs1, instr_rs2;
    logic [WORD_SIZE-1:0] instr_imm;
    logic                 handshake;
    logic                 wb_fire;

    assign instr_opc = instr[OPC_MSB:OPC_LSB];
    assign instr_rd  = instr[RD_MSB:RD_LSB];
    assign instr_rs1 = instr[RS1_MSB:RS1_LSB];
    assign instr_rs2 = instr[RS2_MSB:RS2_LSB];
    assign instr_imm = {{(WORD_SIZE-5){1'b0}}, instr[IMM_MSB:IMM_LSB]};

    assign instr_ready = (state_q == ST_IDLE) && reset_n;
    assign handshake   = instr_valid && instr_ready;
    assign wb_fire     = (state_q == ST_EXEC) && (cnt_q == LAT);

    alu_seq_regfile u_regfile (
        .clock      (clock),
        .reset_n    (reset_n),
        .we_i       (rf_we),
        .waddr_i    (rf_waddr),
        .wdata_i    (rf_wdata),
        .raddr1_i   (instr_rs1),
        .raddr2_i   (instr_rs2),
        .dbg_addr_i (dbg_addr),
        .rdata1_o   (rs1_data),
        .rdata2_o   (rs2_data),
        .dbg_data_o (dbg_data)
    );

    // State and datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            opc_q          <= '0;
            rd_q           <= '0;
            in1_q          <= '0;
            in2_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            illegal_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            opc_q          <= opc_d;
            rd_q           <= rd_d;
            in1_q          <= in1_d;
            in2_q          <= in2_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            illegal_q      <= illegal_d;
        end
    end

    // Next-state, operand capture, write-back and preload selection
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        opc_d          = opc_q;
        rd_d           = rd_q;
        in1_d          = in1_q;
        in2_d          = in2_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        illegal_d      = 1'b0;
        rf_we          = 1'b0;
        rf_waddr       = rd_q;
        rf_wdata       = alu_out;

        unique case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    if (is_supported(instr_opc)) begin
                        opc_d = instr_opc;
                        rd_d  = instr_rd;
                        in1_d = rs1_data;
                        if (instr_opc == OPC_NOT) begin
                            in2_d = '0;
                        end else if (is_itype(instr_opc)) begin
                            in2_d = instr_imm;
                        end else begin
                            in2_d = rs2_data;
                        end
                        cnt_d   = 3'd1;
                        state_d = ST_EXEC;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end else if (init_we) begin
                    rf_we    = 1'b1;
                    rf_waddr = init_addr;
                    rf_wdata = init_data;
                end
            end
            ST_EXEC: begin
                if (wb_fire) begin
                    rf_we          = 1'b1;
                    result_d       = alu_out;
                    result_valid_d = 1'b1;
                    cnt_d          = '0;
                    state_d        = ST_WB;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign alu_opcode   = opc_q;
    assign alu_input1   = in1_q;
    assign alu_input2   = in2_q;
    assign alu_enable   = (state_q == ST_EXEC);
    assign result_valid = result_valid_q;
    assign result_data  = result_q;
    assign illegal_op   = illegal_q;
    assign dbg_state    = state_q;

`ifdef ALU_SEQ_FLAGS_EN
    logic flag_zero_q, flag_lt_q;

    // Result flags, updated only on write-back
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            flag_zero_q <= 1'b0;
            flag_lt_q   <= 1'b0;
        end else if (wb_fire) begin
            flag_zero_q <= (alu_out == '0);
            if (opc_q == OPC_LT) begin
                flag_lt_q <= alu_out[0];
            end
        end
    end

    assign flag_zero = flag_zero_q;
    assign flag_lt   = flag_lt_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a one-register-stage ALU model.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  localparam int LAT = 2;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = '0;
  logic        init_we = 1'b0;
  logic [2:0]  init_addr = '0;
  logic [15:0] init_data = '0;
  logic [4:0]  alu_opcode;
  logic [15:0] alu_input1, alu_input2;
  logic        alu_enable;
  logic [15:0] alu_out = '0;
  logic        result_valid;
  logic [15:0] result_data;
  logic        illegal_op;
  logic [2:0]  dbg_addr = '0;
  logic [15:0] dbg_data;
  logic [1:0]  dbg_state;
`ifdef ALU_SEQ_FLAGS_EN
  logic        flag_zero, flag_lt;
`endif

  alu_sequencer #(.ALU_LATENCY(LAT)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .init_we      (init_we),
    .init_addr    (init_addr),
    .init_data    (init_data),
    .alu_opcode   (alu_opcode),
    .alu_input1   (alu_input1),
    .alu_input2   (alu_input2),
    .alu_enable   (alu_enable),
    .alu_out      (alu_out),
    .result_valid (result_valid),
    .result_data  (result_data),
    .illegal_op   (illegal_op),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data),
    .dbg_state    (dbg_state)
`ifdef ALU_SEQ_FLAGS_EN
    ,
    .flag_zero    (flag_zero),
    .flag_lt      (flag_lt)
`endif
  );

  // ---------------- ALU model ----------------
  function automatic logic [15:0] alu_f(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      OPC_NOT:  return ~a;
      OPC_AND:  return a & b;
      OPC_OR:   return a | b;
      OPC_XOR:  return a ^ b;
      OPC_ADD:  return a + b;
      OPC_ADDI: return a + b;
      OPC_SUB:  return a - b;
      OPC_ANDI: return a & b;
      OPC_EQ:   return {15'd0, a == b};
      OPC_LT:   return {15'd0, a < b};
      default:  return 16'hBAD0;
    endcase
  endfunction

  // Output becomes valid one edge after enable; poisoned while idle so an
  // early sample is visible.
  always @(posedge clock) begin
    if (alu_enable) alu_out <= alu_f(alu_opcode, alu_input1, alu_input2);
    else            alu_out <= 16'hDEAD;
  end

  // ---------------- scoreboard ----------------
  int passed = 0;
  int total = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else passed++;
  endtask

  task automatic sb_compare(input string name);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      check({name, "_sb_nonempty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({name, "_data"}, {16'd0, result_data}, {16'd0, e});
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [15:0] mk_r(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 2'b00};
  endfunction

  function automatic logic [15:0] mk_i(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs1, input logic [4:0] imm);
    return {op, rd, rs1, imm};
  endfunction

  task automatic preload(input logic [2:0] a, input logic [15:0] d);
    @(negedge clock);
    init_we = 1'b1; init_addr = a; init_data = d;
    @(negedge clock);
    init_we = 1'b0;
  endtask

  task automatic dbg_check(input string name, input logic [2:0] a, input logic [15:0] exp);
    dbg_addr = a;
    #1;
    check(name, {16'd0, dbg_data}, {16'd0, exp});
  endtask

  // Offers one instruction; returns at the falling edge right after the
  // accepting edge with e0 = cycle count of that edge.
  task automatic send(input string name, input logic [15:0] w, output int e0);
    int n;
    @(negedge clock);
    instr_valid = 1'b1; instr = w; n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clock); n++;
    end
    if (!instr_ready) check({name, "_ready_timeout"}, {31'd0, instr_ready}, 32'd1);
    @(negedge clock);
    e0 = cyc;
    instr_valid = 1'b0; instr = '0;
  endtask

  task automatic wait_result(input string name, input int e0);
    int n;
    n = 0;
    while (!result_valid && n < 20) begin
      @(negedge clock); n++;
    end
    if (!result_valid) begin
      check({name, "_timeout"}, {31'd0, result_valid}, 32'd1);
    end else begin
      check({name, "_latency"}, 32'(cyc - e0), 32'(LAT));
      sb_compare(name);
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    string       name;
    logic [15:0] word;
    logic [2:0]  rd;
    logic [15:0] exp;
    logic [15:0] exp_dbg;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int e0, low, n;
    bit seen_en, seen_rv;

    // r1=0x1234, r2=0x5678 for all table entries
    vecs[0] = '{"add",   mk_r(OPC_ADD,  3'd3, 3'd1, 3'd2), 3'd3, 16'h68AC, 16'h68AC};
    vecs[1] = '{"sub",   mk_r(OPC_SUB,  3'd4, 3'd2, 3'd1), 3'd4, 16'h4444, 16'h4444};
    vecs[2] = '{"and",   mk_r(OPC_AND,  3'd5, 3'd1, 3'd2), 3'd5, 16'h1230, 16'h1230};
    vecs[3] = '{"or",    mk_r(OPC_OR,   3'd6, 3'd1, 3'd2), 3'd6, 16'h567C, 16'h567C};
    vecs[4] = '{"xor",   mk_r(OPC_XOR,  3'd7, 3'd1, 3'd2), 3'd7, 16'h444C, 16'h444C};
    vecs[5] = '{"not",   mk_r(OPC_NOT,  3'd3, 3'd1, 3'd2), 3'd3, 16'hEDCB, 16'hEDCB};
    vecs[6] = '{"andi",  mk_i(OPC_ANDI, 3'd5, 3'd2, 5'h1F), 3'd5, 16'h0018, 16'h0018};
    vecs[7] = '{"eq",    mk_r(OPC_EQ,   3'd6, 3'd1, 3'd1), 3'd6, 16'h0001, 16'h0001};
    vecs[8] = '{"lt_r0", mk_r(OPC_LT,   3'd0, 3'd1, 3'd2), 3'd0, 16'h0001, 16'h0000};
    vecs[9] = '{"lt_no", mk_r(OPC_LT,   3'd7, 3'd2, 3'd1), 3'd7, 16'h0000, 16'h0000};

    // ---- reset state ----
    repeat (2) @(negedge clock);
    check("rst_ready_low", {31'd0, instr_ready}, 32'd0);
    check("rst_alu_en", {31'd0, alu_enable}, 32'd0);
    check("rst_result_valid", {31'd0, result_valid}, 32'd0);
    check("rst_result_data", {16'd0, result_data}, 32'd0);
    check("rst_illegal", {31'd0, illegal_op}, 32'd0);
    reset_n = 1'b1;
    #1;
    check("rel_ready_high", {31'd0, instr_ready}, 32'd1);
    check("rel_state_idle", {30'd0, dbg_state}, 32'(ST_IDLE));
    dbg_check("rst_r3", 3'd3, 16'h0000);

    // ---- preload, including a discarded write to r0 ----
    preload(3'd1, 16'h1234);
    preload(3'd2, 16'h5678);
    preload(3'd0, 16'hBEEF);
    dbg_check("pre_r1", 3'd1, 16'h1234);
    dbg_check("pre_r2", 3'd2, 16'h5678);
    dbg_check("pre_r0", 3'd0, 16'h0000);

    // ---- table-driven single instructions ----
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(vecs[i].exp);
      send(vecs[i].name, vecs[i].word, e0);
      wait_result(vecs[i].name, e0);
      dbg_check({vecs[i].name, "_dbg"}, vecs[i].rd, vecs[i].exp_dbg);
    end

    // ---- ADDI wrap to zero ----
    preload(3'd1, 16'hFFFF);
    exp_q.push_back(16'h0000);
    send("addi_wrap", mk_i(OPC_ADDI, 3'd4, 3'd1, 5'd1), e0);
    wait_result("addi_wrap", e0);
    dbg_check("addi_wrap_dbg", 3'd4, 16'h0000);
`ifdef ALU_SEQ_FLAGS_EN
    check("flag_zero", {31'd0, flag_zero}, 32'd1);
    check("flag_lt_held", {31'd0, flag_lt}, 32'd0);
`endif

    // ---- back-to-back with dependency, valid held high ----
    preload(3'd1, 16'h1234);
    @(negedge clock);
    instr_valid = 1'b1;
    instr = mk_r(OPC_SUB, 3'd3, 3'd2, 3'd1);
    exp_q.push_back(16'h4444);
    @(negedge clock);
    instr = mk_r(OPC_ADD, 3'd5, 3'd3, 3'd1);
    exp_q.push_back(16'h5678);
    low = 0; n = 0; seen_rv = 1'b0;
    while (!instr_ready && n < 20) begin
      if (result_valid) begin
        seen_rv = 1'b1;
        sb_compare("b2b_first");
      end
      low++;
      @(negedge clock); n++;
    end
    check("b2b_first_seen", {31'd0, seen_rv}, 32'd1);
    check("b2b_ready_low_cycles", 32'(low), 32'd3);
    @(negedge clock);
    e0 = cyc;
    instr_valid = 1'b0; instr = '0;
    wait_result("b2b_second", e0);
    dbg_check("b2b_r3", 3'd3, 16'h4444);
    dbg_check("b2b_r5", 3'd5, 16'h5678);

    // ---- unsupported opcode ----
    send("illegal", mk_r(5'h1F, 3'd1, 3'd2, 3'd2), e0);
    check("illegal_pulse", {31'd0, illegal_op}, 32'd1);
    check("illegal_ready", {31'd0, instr_ready}, 32'd1);
    seen_en = 1'b0; seen_rv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (alu_enable) seen_en = 1'b1;
      if (result_valid) seen_rv = 1'b1;
      @(negedge clock);
      if (k == 0) check("illegal_one_cycle", {31'd0, illegal_op}, 32'd0);
    end
    check("illegal_no_enable", {31'd0, seen_en}, 32'd0);
    check("illegal_no_wb", {31'd0, seen_rv}, 32'd0);
    dbg_check("illegal_r1_kept", 3'd1, 16'h1234);

    // ---- reset during EXEC ----
    send("rst_exec", mk_r(OPC_ADD, 3'd6, 3'd1, 3'd2), e0);
    check("rst_exec_in_exec", {31'd0, alu_enable}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_exec_alu_en", {31'd0, alu_enable}, 32'd0);
    check("rst_exec_opcode", {27'd0, alu_opcode}, 32'd0);
    check("rst_exec_in1", {16'd0, alu_input1}, 32'd0);
    check("rst_exec_in2", {16'd0, alu_input2}, 32'd0);
    check("rst_exec_ready", {31'd0, instr_ready}, 32'd0);
    check("rst_exec_rdata", {16'd0, result_data}, 32'd0);
    dbg_check("rst_exec_r1", 3'd1, 16'h0000);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("rst_exec_ready_rel", {31'd0, instr_ready}, 32'd1);
    seen_rv = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (result_valid) seen_rv = 1'b1;
      @(negedge clock);
    end
    check("rst_exec_no_wb", {31'd0, seen_rv}, 32'd0);
    dbg_check("rst_exec_r6", 3'd6, 16'h0000);

    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
